sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Single-clock arbiter and sequencer that shares one external 16+16-bit SRAM bank pair (32-bit word) among NREQ requesters (VGA refresh, CPU vram, sdram emulation, microcode load).
- Requester 0 is real-time (VGA) and has fixed top priority; requesters 1..NREQ-1 share the remaining slots round-robin.
- Generates SRAM address, strobes and data-bus enable with a programmable strobe width, and returns read data with a one-cycle ack per access.

Parameters:
- NREQ, 4, number of requesters (2..8); index 0 is priority.
- AW, 18, SRAM word address width.
- WAIT_STATES, 1, extra strobe cycles beyond the first (0..7).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request; held high until ack.
- we  in  NREQ  per-requester write enable; 1=write, 0=read; sampled at grant.
- addr  in  NREQ*AW  flattened addresses; slice i = addr[i*AW +: AW].
- wdata  in  NREQ*32  flattened write data.
- gnt  out  NREQ  one-hot; owner of the current access.
- ack  out  NREQ  one-cycle pulse; read data valid / write complete.
- rdata  out  32  shared read data; valid while ack is high, held until next read.
- sram_a  out  AW  SRAM address.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_dq_oe  out  1  1 = drive sram_dout onto the bus.
- sram_dout  out  32  write data to the pads.
- sram_din  in  32  read data from the pads.

Behaviour:
- Reset values: gnt=0, ack=0, rdata=0, sram_a=0, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_dout=0, rr_ptr=1, state=IDLE.
- Reset is asynchronous. Asserting it mid-access deasserts all strobes immediately and drops the access with no ack.
- State machine: IDLE, SETUP, STROBE, DONE.
- IDLE: if any req, arbitrate, register gnt, latch we/addr/wdata of the winner, and go to SETUP.
- Arbitration: req[0] wins if set. Otherwise the first set req at or after rr_ptr among 1..NREQ-1, wrapping from NREQ-1 to 1. After a non-zero grant k, rr_ptr = k+1, wrapping to 1. Grants to requester 0 leave rr_ptr unchanged.
- SETUP (1 cycle): sram_a valid; strobes high. sram_dq_oe=1 for a write.
- STROBE (WAIT_STATES+1 cycles, counter): sram_oe_n=0 for a read; sram_we_n=0 for a write. sram_a and sram_dout are stable throughout. On the final STROBE edge a read captures sram_din into rdata.
- DONE (1 cycle): ack[owner]=1; strobes high. sram_dq_oe stays 1 for a write through DONE, giving hold time. gnt clears at the end of DONE.
- DONE also arbitrates for back-to-back accesses. The owner's req is masked during this cycle. Any other pending req goes straight to SETUP; otherwise the machine returns to IDLE.
- Access time from grant to ack = 3+WAIT_STATES cycles. The bus is never idle between back-to-back accesses except for the SETUP cycle.
- Withdrawn request: if req drops after grant, the access still completes and ack is still issued.
- Simultaneous req on all lines: 0 is served every other slot at most (DONE masks it once). Round-robin guarantees any requester k≥1 is served within NREQ-1 non-zero grants.
- addr and wdata are latched at grant, so requester changes during an access are ignored.

Optional Feature:
- ARB_STATS_EN.
- Defined: adds output stat_gnt_cnt (NREQ*16, flattened) with per-requester saturating grant counters, and output stat_max_wait (16), the longest req-to-gnt wait in cycles seen by any requester. Both are cleared by reset_n and by input stat_clr (1 bit, synchronous).
- Undefined: these ports and their logic are absent, and arbitration timing is identical.

Decomposition:
- Package sram_arb_pkg holds the state encodings (IDLE=0, SETUP=1, STROBE=2, DONE=3), the NREQ maximum and the WAIT_STATES width constant.
- One sub-module, rr_pick: combinational round-robin pointer search returning a one-hot winner over requesters 1..NREQ-1.
- Sequencing FSM and datapath latches stay in sram_arbiter.

Test Plan:
- Single read, WAIT_STATES=1: req[2], we=0, addr=18'h00123, sram_din model returns 32'hdeadbeef → gnt[2] next cycle; oe_n low for 2 cycles; ack[2] 4 cycles after grant with rdata=32'hdeadbeef.
- Single write by req[1], addr=18'h2a000, wdata=32'h12345678 → we_n low for exactly 2 cycles with sram_a=18'h2a000 and sram_dout=32'h12345678 stable; dq_oe high SETUP through DONE; ack[1] pulse.
- req[1..3] held continuously → grant order 1,2,3,1,2,3 with back-to-back accesses (no IDLE cycles).
- req[0] and req[3] held → order 0,3,0,3 (requester 0 masked in its own DONE); req[3] never starved.
- reset_n pulled low during STROBE of a write → we_n=1 and dq_oe=0 asynchronously; no ack. After release, a pending req is re-granted from IDLE with rr_ptr=1.
- With ARB_STATS_EN: 5 grants to requester 2, then stat_clr → stat_gnt_cnt slice 2 reads 5, then 0 the cycle after stat_clr.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - state encoding and sizing constants shared by the SRAM arbiter files
package sram_arb_pkg;
    localparam int NREQ_MAX = 8;
    localparam int PTR_W    = $clog2(NREQ_MAX);
    localparam int WS_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin search over requesters 1..NREQ-1 starting at ptr
// Returns a one-hot winner (bit 0 always clear) and its index.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:1]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [PTR_W-1:0] win_idx
);
    logic             hi_hit;
    logic             lo_hit;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;

    // Descending scan leaves the lowest set index in each half: at/after ptr, then wrapped.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NREQ - 1; j >= 1; j--) begin
            if (req[j]) begin
                if (j >= int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = PTR_W'(j);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = PTR_W'(j);
                end
            end
        end
        win_idx = hi_hit ? hi_idx : lo_idx;
        win     = (hi_hit || lo_hit) ? (NREQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shared 32-bit SRAM arbiter/sequencer, requester 0 fixed priority, rest round-robin
// Optional grant/wait statistics are built when ARB_STATS_EN is defined.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int AW          = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*32-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [31:0]       rdata,
    output logic [AW-1:0]     sram_a,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_dq_oe,
    output logic [31:0]       sram_dout,
    input  logic [31:0]       sram_din
`ifdef ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [NREQ*16-1:0] stat_gnt_cnt,
    output logic [15:0]       stat_max_wait
`endif
);
    arb_state_t       state;
    arb_state_t       state_n;
    logic [WS_W-1:0]  cnt;
    logic             own_we;
    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  cand;
    logic             take;
    logic [NREQ-1:0]  pick_oh;
    logic [NREQ-1:0]  rr_oh;
    logic [PTR_W-1:0] rr_idx;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [31:0]      sel_wdata;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req     (cand[NREQ-1:1]),
        .ptr     (rr_ptr),
        .win     (rr_oh),
        .win_idx (rr_idx)
    );

    // The owner is masked in DONE so another requester can take the very next slot.
    always_comb begin
        cand    = req & ((state == DONE) ? ~gnt : '1);
        take    = ((state == IDLE) || (state == DONE)) && (|cand);
        pick_oh = cand[0] ? NREQ'(1) : rr_oh;
        state_n = state;
        case (state)
            IDLE:    if (take) state_n = SETUP;
            SETUP:   state_n = STROBE;
            STROBE:  if (cnt == '0) state_n = DONE;
            DONE:    state_n = take ? SETUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            own_we     <= 1'b0;
            rr_ptr     <= PTR_W'(1);
            gnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            sram_a     <= '0;
            sram_dout  <= '0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            state <= state_n;
            ack   <= '0;
            if (take) begin
                gnt       <= pick_oh;
                own_we    <= sel_we;
                sram_a    <= sel_addr;
                sram_dout <= sel_wdata;
                if (!cand[0])
                    rr_ptr <= (rr_idx == PTR_W'(NREQ - 1)) ? PTR_W'(1) : rr_idx + PTR_W'(1);
            end else if (state == DONE) begin
                gnt <= '0;
            end
            if (state == SETUP)
                cnt <= WS_W'(WAIT_STATES);
            else if (state == STROBE)
                cnt <= cnt - 1'b1;
            if ((state == STROBE) && (cnt == '0)) begin
                ack <= gnt;
                if (!own_we)
                    rdata <= sram_din;
            end
            // Strobes are registered from the next state so the pads see glitch-free levels.
            sram_oe_n  <= !((state_n == STROBE) && !own_we);
            sram_we_n  <= !((state_n == STROBE) && own_we);
            sram_dq_oe <= (state_n == SETUP) ? sel_we
                        : (((state_n == STROBE) || (state_n == DONE)) && own_we);
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] wait_cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_gnt_cnt  <= '0;
            stat_max_wait <= '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else if (stat_clr) begin
            stat_gnt_cnt  <= '0;
            stat_max_wait <= '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (take && pick_oh[i]) begin
                    if (stat_gnt_cnt[i*16 +: 16] != 16'hffff)
                        stat_gnt_cnt[i*16 +: 16] <= stat_gnt_cnt[i*16 +: 16] + 16'd1;
                    if (wait_cnt[i] > stat_max_wait)
                        stat_max_wait <= wait_cnt[i];
                    wait_cnt[i] <= '0;
                end else if (req[i] && !gnt[i]) begin
                    if (wait_cnt[i] != 16'hffff)
                        wait_cnt[i] <= wait_cnt[i] + 16'd1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized scoreboard bench for sram_arbiter with a slot-level arbitration model
module tb_sram_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 18;
    localparam int WS   = 1;
    localparam int NTX  = 20;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*32-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [31:0]       rdata;
    logic [AW-1:0]     sram_a;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_dq_oe;
    logic [31:0]       sram_dout;
    logic [31:0]       sram_din;
`ifdef ARB_STATS_EN
    logic              stat_clr;
    logic [NREQ*16-1:0] stat_gnt_cnt;
    logic [15:0]       stat_max_wait;
`endif

    sram_arbiter #(.NREQ(NREQ), .AW(AW), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .sram_a     (sram_a),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_dq_oe (sram_dq_oe),
        .sram_dout  (sram_dout),
        .sram_din   (sram_din)
`ifdef ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_gnt_cnt  (stat_gnt_cnt),
        .stat_max_wait (stat_max_wait)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic            r_req   [NREQ];
    logic            r_we    [NREQ];
    logic [AW-1:0]   r_addr  [NREQ];
    logic [31:0]     r_wdata [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = r_req[i];
            we[i]               = r_we[i];
            addr[i*AW +: AW]    = r_addr[i];
            wdata[i*32 +: 32]   = r_wdata[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] dflt(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    // SRAM device: writes land while we_n is low, read data is presented while oe_n is low.
    logic [31:0] dev_mem [logic [AW-1:0]];
    always @(negedge clk) begin
        if (reset_n && !sram_we_n) dev_mem[sram_a] = sram_dout;
        sram_din = sram_oe_n ? 32'h0 : (dev_mem.exists(sram_a) ? dev_mem[sram_a] : dflt(sram_a));
    end

    // Reference memory and per-requester expected responses {is_read, data}.
    logic [31:0] ref_mem [logic [AW-1:0]];
    logic [32:0] exp_q [NREQ][$];

    task automatic issue(input int id, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        r_we[id]    = w;
        r_addr[id]  = a;
        r_wdata[id] = d;
        if (w) begin
            ref_mem[a] = d;
            exp_q[id].push_back({1'b0, d});
        end else begin
            exp_q[id].push_back({1'b1, ref_mem.exists(a) ? ref_mem[a] : dflt(a)});
        end
        r_req[id] = 1'b1;
    endtask

    task automatic wait_ack(input int id, input bit withdraw);
        bit got = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(posedge clk);
            #1;
            if (ack[id]) begin
                r_req[id] = 1'b0;
                got = 1;
            end else if (withdraw && gnt[id]) begin
                r_req[id] = 1'b0;
            end
        end
        check($sformatf("ack_timeout_%0d", id), 64'(got), 64'(1));
    endtask

    task automatic agent(input int id);
        for (int n = 0; n < NTX; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(id, 1'($urandom_range(0, 1)), {2'(id), 12'h0, 4'($urandom)}, 32'($urandom));
            wait_ack(id, $urandom_range(0, 7) == 0);
        end
    endtask

    // Slot model: round-robin order kept as a rotating list; requester 0 always first.
    int order[$];
    int age;
    int own;
    logic          own_we;
    logic [AW-1:0] own_a;
    logic [31:0]   own_d;
    logic [NREQ-1:0] p_req, p_gnt, p_ack, p_we;
    logic [AW-1:0] p_addr [NREQ];
    logic [31:0]   p_wdata [NREQ];
    bit pv;

    function automatic int pick(input logic [NREQ-1:0] m);
        if (m[0]) return 0;
        foreach (order[j]) if (m[order[j]]) return order[j];
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            pv  = 0;
            age = -1;
            order = {};
            for (int k = 1; k < NREQ; k++) order.push_back(k);
        end else begin
            if (pv) begin
                if (p_gnt == '0 || p_ack != '0) begin
                    int w;
                    logic [NREQ-1:0] eg;
                    w  = pick(p_req & ~p_ack);
                    eg = (w < 0) ? '0 : (NREQ'(1) << w);
                    check("gnt_pick", 64'(gnt), 64'(eg));
                    if (w >= 0) begin
                        age = 0; own = w; own_we = p_we[w];
                        own_a = p_addr[w]; own_d = p_wdata[w];
                        if (w > 0) begin
                            while (order[0] != w) order.push_back(order.pop_front());
                            order.push_back(order.pop_front());
                        end
                    end else begin
                        age = -1;
                    end
                end else begin
                    check("gnt_hold", 64'(gnt), 64'(p_gnt));
                    age++;
                end
                begin
                    logic [NREQ+2:0] eb;
                    logic [NREQ-1:0] ea;
                    ea = NREQ'(1) << own;
                    if (age < 0)            eb = {NREQ'(0), 3'b110};
                    else if (age == 0)      eb = {NREQ'(0), 2'b11, own_we};
                    else if (age <= WS + 1) eb = {NREQ'(0), own_we, !own_we, own_we};
                    else                    eb = {ea, 2'b11, own_we};
                    check("bus", 64'({ack, sram_oe_n, sram_we_n, sram_dq_oe}), 64'(eb));
                    if (age >= 0) check("sram_a", 64'(sram_a), 64'(own_a));
                    if (age >= 1 && age <= WS + 1 && own_we)
                        check("sram_dout", 64'(sram_dout), 64'(own_d));
                end
            end
            p_req = req; p_gnt = gnt; p_ack = ack; p_we = we;
            for (int i = 0; i < NREQ; i++) begin
                p_addr[i]  = r_addr[i];
                p_wdata[i] = r_wdata[i];
            end
            pv = 1;
        end
    end

    // Scoreboard: every ack pops that requester's oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    check("ack_pending", 64'(exp_q[i].size() > 0), 64'(1));
                    if (exp_q[i].size() > 0) begin
                        logic [32:0] e;
                        e = exp_q[i].pop_front();
                        if (e[32]) check($sformatf("rdata_%0d", i), 64'(rdata), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'({gnt, ack, sram_oe_n, sram_we_n, sram_dq_oe}), 64'({2*NREQ'(0), 3'b110}));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_sram_a", 64'(sram_a), 64'(0));
        check("rst_dout", 64'(sram_dout), 64'(0));
        @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < NREQ; i++) begin
            fork
                automatic int id = i;
                agent(id);
            join_none
        end
        wait fork;

        // Kill a write mid-strobe; afterwards the rr pointer must restart at 1.
        @(posedge clk);
        #1;
        issue(2, 1'b1, 18'h2a000, 32'h1234_5678);
        for (int t = 0; t < 50 && sram_we_n; t++) @(negedge clk);
        check("we_low_seen", 64'(sram_we_n), 64'(0));
        #1;
        issue(3, 1'b0, {2'd3, 16'h0005}, 32'h0);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst", 64'({gnt, ack, sram_oe_n, sram_we_n, sram_dq_oe}), 64'({2*NREQ'(0), 3'b110}));
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        wait_ack(2, 0);
        wait_ack(3, 0);

`ifdef ARB_STATS_EN
        @(posedge clk);
        #1 stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            issue(2, 1'b0, {2'd2, 16'(n)}, 32'h0);
            wait_ack(2, 0);
        end
        @(posedge clk);
        #1;
        check("stat_cnt2", 64'(stat_gnt_cnt[32 +: 16]), 64'(5));
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        check("stat_clr", 64'(stat_gnt_cnt[32 +: 16]), 64'(0));
`endif

        repeat (4) @(posedge clk);
        for (int i = 0; i < NREQ; i++)
            check($sformatf("drain_%0d", i), 64'(exp_q[i].size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $fatal(1);
    end
endmodule
